spi_slave_dev: RTL and testbench

SPI slave peripheral for the AVR I/O space and the slave-side counterpart of the SPI master device. It exposes the AVR-style SPCR/SPSR/SPDR registers on the CPU I/O bus. An external master drives SCLK, SS and MOSI; the block oversamples them on `clk_i` and shifts data in and out on MISO, supporting all four CPOL/CPHA modes and both bit orders. It raises SPIF per received byte, with WCOL collision detection.

---
 rtl/spi_slave_dev.sv | 182 ++++++++++++++++++
 tb/tb_spi_slave_dev.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_dev.sv
// spi_slave_dev: AVR-style SPI slave on the CPU I/O bus.
//
// Exposes SPCR/SPSR/SPDR. The external master drives SCLK/SS/MOSI; those pins
// are oversampled on clk_i and the byte is shifted in and out on MISO in any of
// the four CPOL/CPHA modes, MSB- or LSB-first. SPIF is raised once per received
// byte; writing SPDR mid-byte sets WCOL instead of loading the shift register.
//
// Ports
//   clk_i, rst_i        system clock, asynchronous active-low reset
//   ena_i, adr_i        bus cycle qualifier, 6-bit I/O address
//   data_i, data_o      write data, combinational read data (0 when unselected)
//   re_i, we_i          read / write strobes
//   selected_o          address hit with a read or write strobe
//   irq_req_o           SPIF & SPIE
//   irq_ack_i           interrupt acknowledge, clears SPIF
//   mux_en_o            SPE, claims the shared pins
//   sclk_i, ss_ni       external SPI clock and active-low select (asynchronous)
//   mosi_i              external serial data in (asynchronous)
//   miso_o, miso_en_o   serial data out and its output enable

module spi_slave_dev #(
    parameter int ENABLE      = 1,
    parameter int WCOL_ENABLE = 1,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       ena_i,
    input  logic [5:0] adr_i,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    input  logic       re_i,
    input  logic       we_i,
    output logic       selected_o,
    output logic       irq_req_o,
    input  logic       irq_ack_i,
    output logic       mux_en_o,
    input  logic       sclk_i,
    input  logic       ss_ni,
    input  logic       mosi_i,
    output logic       miso_o,
    output logic       miso_en_o
);

    localparam logic [5:0] SPCR_ADDRESS = 6'h0D;
    localparam logic [5:0] SPSR_ADDRESS = 6'h0E;
    localparam logic [5:0] SPDR_ADDRESS = 6'h0F;

    logic [7:0] spcr;
    logic       spif;
    logic       wcol;
    logic [7:0] sr;
    logic [7:0] rxbuf;
    logic [2:0] cnt;
    logic       lat;

    logic [SYNC_STAGES-1:0] sclk_q;
    logic [SYNC_STAGES-1:0] ss_q;
    logic [SYNC_STAGES-1:0] mosi_q;
    logic                   s_d;

    logic spie, spe, dord, cpol, cpha;
    logic s, ss_s, mosi_s;
    logic hit_spcr, hit_spsr, hit_spdr;
    logic wr_spcr, wr_spdr, rd_spdr, acc_spdr;
    logic active, busy, edge_s, lead, trail;
    logic sample_e, shift_e, last_e, direct_e;
    logic [7:0] sr_in, sr_lat;

    assign spie = spcr[7];
    assign spe  = spcr[6];
    assign dord = spcr[5];
    assign cpol = spcr[3];
    assign cpha = spcr[2];

    assign s      = sclk_q[SYNC_STAGES-1];
    assign ss_s   = ss_q[SYNC_STAGES-1];
    assign mosi_s = mosi_q[SYNC_STAGES-1];

    // SS synchronizer resets to the idle (high) level so no transfer appears
    // to start on reset release.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            sclk_q <= '0;
            ss_q   <= '1;
            mosi_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sclk_q <= {sclk_q[SYNC_STAGES-2:0], sclk_i};
            ss_q   <= {ss_q[SYNC_STAGES-2:0], ss_ni};
            mosi_q <= {mosi_q[SYNC_STAGES-2:0], mosi_i};
            s_d    <= s;
        end
    end

    assign hit_spcr   = (ENABLE != 0) && (adr_i == SPCR_ADDRESS);
    assign hit_spsr   = (ENABLE != 0) && (adr_i == SPSR_ADDRESS);
    assign hit_spdr   = (ENABLE != 0) && (adr_i == SPDR_ADDRESS);
    assign selected_o = (hit_spcr | hit_spsr | hit_spdr) & (re_i | we_i);

    assign wr_spcr  = hit_spcr & we_i & ena_i;
    assign wr_spdr  = hit_spdr & we_i & ena_i;
    assign rd_spdr  = hit_spdr & re_i & ena_i;
    assign acc_spdr = hit_spdr & (re_i | we_i) & ena_i;

    always_comb begin
        data_o = '0;
        if (selected_o) begin
            if (hit_spcr)      data_o = spcr;
            else if (hit_spsr) data_o = {spif, wcol, 6'b0};
            else               data_o = rxbuf;
        end
    end

    assign active = spe & ~ss_s;
    assign busy   = active & (cnt != 3'd0);
    assign edge_s = s ^ s_d;
    assign lead   = edge_s & (s_d == cpol);
    assign trail  = edge_s & (s_d != cpol);

    assign sample_e = active & (cpha ? trail : lead);
    // CPHA=0 shifts on the trailing edge after each sample except the 8th; the
    // count is 0 there because the 8th sample already completed the byte.
    assign shift_e  = active & ~cpha & trail & (cnt != 3'd0);
    assign last_e   = sample_e & (cnt == 3'd7);
    // With CPHA=1, and for the final bit of CPHA=0, the sampled bit goes
    // straight into sr so the completed byte is available at the sample edge.
    assign direct_e = sample_e & (cpha | last_e);

    assign sr_in  = dord ? {mosi_s, sr[7:1]} : {sr[6:0], mosi_s};
    assign sr_lat = dord ? {lat, sr[7:1]}    : {sr[6:0], lat};

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            spcr  <= '0;
            spif  <= 1'b0;
            wcol  <= 1'b0;
            sr    <= '0;
            rxbuf <= '0;
            cnt   <= '0;
            lat   <= 1'b0;
        end else begin
            if (wr_spcr)
                spcr <= data_i & 8'hEF;

            if (!active)
                cnt <= '0;
            else if (sample_e)
                cnt <= cnt + 3'd1;

            if (sample_e)
                lat <= mosi_s;

            // A legal (non-busy) CPU load wins over a same-cycle shift.
            if (wr_spdr && !busy)
                sr <= data_i;
            else if (direct_e)
                sr <= sr_in;
            else if (shift_e)
                sr <= sr_lat;

            if (last_e)
                rxbuf <= sr_in;

            if (last_e)
                spif <= 1'b1;
            else if (irq_ack_i || acc_spdr)
                spif <= 1'b0;

            if ((WCOL_ENABLE != 0) && wr_spdr && busy)
                wcol <= 1'b1;
            else if (rd_spdr)
                wcol <= 1'b0;
        end
    end

    assign irq_req_o = spif & spie;
    assign mux_en_o  = spe;
    assign miso_en_o = active;
    assign miso_o    = active & (dord ? sr[0] : sr[7]);

endmodule

// File: tb/tb_spi_slave_dev.sv
// Bench for spi_slave_dev: acts as the SPI master and the CPU, and compares
// against a byte-level model of what the slave should hold and transmit.

module tb_spi_slave_dev;

    localparam int H = 6;
    localparam logic [5:0] A_SPCR = 6'h0D;
    localparam logic [5:0] A_SPSR = 6'h0E;
    localparam logic [5:0] A_SPDR = 6'h0F;

    logic       clk_i = 1'b0;
    logic       rst_i, ena_i, re_i, we_i, irq_ack_i, sclk_i, ss_ni, mosi_i;
    logic [5:0] adr_i;
    logic [7:0] data_i;
    logic [7:0] data_o, nw_data_o;
    logic       selected_o, irq_req_o, mux_en_o, miso_o, miso_en_o;
    logic       nw_selected_o, nw_irq_req_o, nw_mux_en_o, nw_miso_o, nw_miso_en_o;

    spi_slave_dev dut (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .adr_i(adr_i),
        .data_i(data_i), .data_o(data_o), .re_i(re_i), .we_i(we_i),
        .selected_o(selected_o), .irq_req_o(irq_req_o), .irq_ack_i(irq_ack_i),
        .mux_en_o(mux_en_o), .sclk_i(sclk_i), .ss_ni(ss_ni), .mosi_i(mosi_i),
        .miso_o(miso_o), .miso_en_o(miso_en_o)
    );

    spi_slave_dev #(.WCOL_ENABLE(0)) dut_nw (
        .clk_i(clk_i), .rst_i(rst_i), .ena_i(ena_i), .adr_i(adr_i),
        .data_i(data_i), .data_o(nw_data_o), .re_i(re_i), .we_i(we_i),
        .selected_o(nw_selected_o), .irq_req_o(nw_irq_req_o), .irq_ack_i(irq_ack_i),
        .mux_en_o(nw_mux_en_o), .sclk_i(sclk_i), .ss_ni(ss_ni), .mosi_i(mosi_i),
        .miso_o(nw_miso_o), .miso_en_o(nw_miso_en_o)
    );

    always #5 clk_i = ~clk_i;

    int vectors = 0;
    int miscompares = 0;

    bit         cpol, cpha, dord;
    logic [7:0] m_rx, exp_sr, rd, rd2, d, m;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: shift register contents after n bits of m were clocked in and the
    // transfer was then aborted.
    function automatic logic [7:0] partial(input logic [7:0] old, input logic [7:0] mb,
                                           input int n, input bit lsb_first);
        logic [15:0] t;
        if (!lsb_first) begin
            t = {old, mb} << n;
            return t[15:8];
        end else begin
            t = {mb, old} >> n;
            return t[7:0];
        end
    endfunction

    task automatic cpu_write(input logic [5:0] a, input logic [7:0] v);
        @(negedge clk_i);
        adr_i = a; data_i = v; we_i = 1'b1; ena_i = 1'b1;
        @(negedge clk_i);
        we_i = 1'b0; ena_i = 1'b0;
    endtask

    task automatic cpu_read(input logic [5:0] a, output logic [7:0] v, output logic [7:0] v2);
        @(negedge clk_i);
        adr_i = a; re_i = 1'b1; ena_i = 1'b1;
        #1;
        v = data_o;
        v2 = nw_data_o;
        @(negedge clk_i);
        re_i = 1'b0; ena_i = 1'b0;
    endtask

    task automatic rd_check(input logic [5:0] a, input logic [7:0] exp, input string tag);
        cpu_read(a, rd, rd2);
        chk(tag, 32'(rd), 32'(exp));
    endtask

    task automatic ss_set(input logic v);
        @(negedge clk_i);
        ss_ni = v;
        repeat (H) @(negedge clk_i);
    endtask

    task automatic set_mode(input bit po, input bit ph, input bit lsb, input bit ie);
        @(negedge clk_i);
        sclk_i = po;
        repeat (H) @(negedge clk_i);
        cpol = po; cpha = ph; dord = lsb;
        cpu_write(A_SPCR, {ie, 1'b1, lsb, 1'b0, po, ph, 2'b00});
    endtask

    task automatic bit_xfer(input logic b, output logic r);
        if (!cpha) begin
            mosi_i = b;
            repeat (H) @(negedge clk_i);
            r = miso_o;
            sclk_i = ~cpol;
            repeat (H) @(negedge clk_i);
            sclk_i = cpol;
        end else begin
            sclk_i = ~cpol;
            mosi_i = b;
            repeat (H) @(negedge clk_i);
            r = miso_o;
            sclk_i = cpol;
            repeat (H) @(negedge clk_i);
        end
    endtask

    task automatic xfer_bits(input logic [7:0] tx, input int from, input int to);
        logic r;
        int   idx;
        for (int i = from; i < to; i++) begin
            idx = dord ? i : 7 - i;
            bit_xfer(tx[idx], r);
            m_rx[idx] = r;
        end
    endtask

    task automatic full_byte(input logic [7:0] mb, input string tag);
        m_rx = '0;
        xfer_bits(mb, 0, 8);
        repeat (H) @(negedge clk_i);
        chk({tag, "_miso"}, 32'(m_rx), 32'(exp_sr));
        exp_sr = mb;
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i = 1'b0; ena_i = 1'b0; re_i = 1'b0; we_i = 1'b0; irq_ack_i = 1'b0;
        sclk_i = 1'b0; ss_ni = 1'b1; mosi_i = 1'b0; adr_i = '0; data_i = '0;
        cpol = 0; cpha = 0; dord = 0; m_rx = '0;
        repeat (3) @(negedge clk_i);
        #1;
        chk("rst_irq", 32'(irq_req_o), 0);
        chk("rst_mux", 32'(mux_en_o), 0);
        chk("rst_miso", 32'(miso_o), 0);
        chk("rst_misoen", 32'(miso_en_o), 0);
        chk("rst_data", 32'(data_o), 0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        rd_check(A_SPCR, 8'h00, "rst_spcr");
        rd_check(A_SPSR, 8'h00, "rst_spsr");
        rd_check(A_SPDR, 8'h00, "rst_spdr");

        // Decode
        @(negedge clk_i);
        adr_i = 6'h10; re_i = 1'b1; ena_i = 1'b1;
        #1;
        chk("sel_miss", 32'(selected_o), 0);
        chk("data_miss", 32'(data_o), 0);
        adr_i = A_SPSR;
        #1;
        chk("sel_hit", 32'(selected_o), 1);
        re_i = 1'b0;
        #1;
        chk("sel_nostrobe", 32'(selected_o), 0);
        ena_i = 1'b0;

        // Mode 0 basic transfer; MSTR ignored, SPR kept
        cpu_write(A_SPCR, 8'h53);
        rd_check(A_SPCR, 8'h43, "spcr_mstr");
        cpol = 0; cpha = 0; dord = 0;
        cpu_write(A_SPDR, 8'hA5);
        exp_sr = 8'hA5;
        ss_set(1'b0);
        chk("mux_en", 32'(mux_en_o), 1);
        full_byte(8'h3C, "m0");
        chk("irq_spie0", 32'(irq_req_o), 0);
        rd_check(A_SPSR, 8'h80, "m0_spsr");
        cpu_write(A_SPCR, 8'hC3);
        #1;
        chk("irq_spie1", 32'(irq_req_o), 1);
        rd_check(A_SPDR, 8'h3C, "m0_rx");
        #1;
        chk("irq_cleared", 32'(irq_req_o), 0);
        rd_check(A_SPSR, 8'h00, "m0_spsr_clr");
        ss_set(1'b1);

        // All modes, both bit orders, echo of unwritten byte
        for (int md = 0; md < 4; md++) begin
            for (int dd = 0; dd < 2; dd++) begin
                set_mode(bit'((md >> 1) & 1), bit'(md & 1), bit'(dd), 1'b0);
                d = 8'($urandom_range(255));
                cpu_write(A_SPDR, d);
                exp_sr = d;
                ss_set(1'b0);
                #1;
                chk("misoen_on", 32'(miso_en_o), 1);
                full_byte(8'h81, "m81");
                rd_check(A_SPSR, 8'h80, "spif81");
                rd_check(A_SPDR, 8'h81, "rx81");
                full_byte(8'h7E, "m7e");
                rd_check(A_SPDR, 8'h7E, "rx7e");
                m = 8'($urandom_range(255));
                full_byte(m, "mrnd");
                rd_check(A_SPDR, m, "rxrnd");
                ss_set(1'b1);
                #1;
                chk("misoen_off", 32'(miso_en_o), 0);
            end
        end

        // Collision after 3 bits
        set_mode(1'b0, 1'b0, 1'b0, 1'b0);
        d = 8'($urandom_range(255));
        cpu_write(A_SPDR, d);
        exp_sr = d;
        ss_set(1'b0);
        m = 8'($urandom_range(255));
        m_rx = '0;
        xfer_bits(m, 0, 3);
        cpu_write(A_SPDR, ~d);
        cpu_read(A_SPSR, rd, rd2);
        chk("wcol_set", 32'(rd), 32'h40);
        chk("wcol_disabled", 32'(rd2), 32'h00);
        xfer_bits(m, 3, 8);
        repeat (H) @(negedge clk_i);
        chk("wcol_sr_kept", 32'(m_rx), 32'(d));
        exp_sr = m;
        cpu_read(A_SPSR, rd, rd2);
        chk("wcol_spsr", 32'(rd), 32'hC0);
        chk("wcol_spsr_nw", 32'(rd2), 32'h80);
        rd_check(A_SPDR, m, "wcol_rx");
        rd_check(A_SPSR, 8'h00, "wcol_clr");
        ss_set(1'b1);

        // SS abort after 5 bits
        for (int k = 0; k < 2; k++) begin
            set_mode(bit'(k), bit'(k), bit'(k), 1'b0);
            d = 8'($urandom_range(255));
            cpu_write(A_SPDR, d);
            exp_sr = d;
            ss_set(1'b0);
            m = 8'($urandom_range(255));
            xfer_bits(m, 0, 5);
            ss_set(1'b1);
            rd_check(A_SPSR, 8'h00, "abort_nospif");
            exp_sr = partial(exp_sr, m, 5, dord);
            ss_set(1'b0);
            full_byte(8'h55, "abort55");
            rd_check(A_SPSR, 8'h80, "abort_spif");
            rd_check(A_SPDR, 8'h55, "abort_rx");
            ss_set(1'b1);
        end

        // irq_ack in the cycle SPIF sets; also pins the pin-to-SPIF latency
        set_mode(1'b0, 1'b0, 1'b0, 1'b1);
        d = 8'($urandom_range(255));
        cpu_write(A_SPDR, d);
        ss_set(1'b0);
        m = 8'($urandom_range(255));
        xfer_bits(m, 0, 7);
        mosi_i = m[0];
        repeat (H) @(negedge clk_i);
        sclk_i = 1'b1;
        @(posedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        #1;
        chk("simul_pre", 32'(irq_req_o), 0);
        irq_ack_i = 1'b1;
        @(negedge clk_i);
        irq_ack_i = 1'b0;
        #1;
        chk("simul_set", 32'(irq_req_o), 1);
        repeat (H) @(negedge clk_i);
        sclk_i = 1'b0;
        repeat (H) @(negedge clk_i);
        rd_check(A_SPDR, m, "simul_rx");
        exp_sr = m;
        ss_set(1'b1);

        // SPE=0 ignores SCLK
        cpu_write(A_SPCR, 8'h00);
        ss_set(1'b0);
        #1;
        chk("spe0_misoen", 32'(miso_en_o), 0);
        chk("spe0_mux", 32'(mux_en_o), 0);
        cpol = 0; cpha = 0; dord = 0;
        xfer_bits(8'($urandom_range(255)), 0, 5);
        repeat (H) @(negedge clk_i);
        rd_check(A_SPSR, 8'h00, "spe0_nospif");
        ss_set(1'b1);
        set_mode(1'b0, 1'b0, 1'b0, 1'b0);
        d = 8'($urandom_range(255));
        cpu_write(A_SPDR, d);
        exp_sr = d;
        ss_set(1'b0);
        m = 8'($urandom_range(255));
        full_byte(m, "spe0_after");
        rd_check(A_SPDR, m, "spe0_rx");
        ss_set(1'b1);

        // Reset mid-byte
        set_mode(1'b0, 1'b0, 1'b0, 1'b1);
        d = 8'($urandom_range(255));
        cpu_write(A_SPDR, d);
        exp_sr = d;
        ss_set(1'b0);
        full_byte(8'($urandom_range(255)), "pre_rst");
        #1;
        chk("pre_rst_irq", 32'(irq_req_o), 1);
        xfer_bits(8'($urandom_range(255)), 0, 4);
        @(negedge clk_i);
        rst_i = 1'b0;
        adr_i = A_SPCR; re_i = 1'b1; ena_i = 1'b1;
        #1;
        chk("mid_rst_data", 32'(data_o), 0);
        chk("mid_rst_irq", 32'(irq_req_o), 0);
        chk("mid_rst_mux", 32'(mux_en_o), 0);
        chk("mid_rst_miso", 32'(miso_o), 0);
        chk("mid_rst_misoen", 32'(miso_en_o), 0);
        re_i = 1'b0; ena_i = 1'b0;
        sclk_i = 1'b0; ss_ni = 1'b1;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b1;
        repeat (H) @(negedge clk_i);
        rd_check(A_SPCR, 8'h00, "post_rst_spcr");
        rd_check(A_SPSR, 8'h00, "post_rst_spsr");
        rd_check(A_SPDR, 8'h00, "post_rst_spdr");
        exp_sr = 8'h00;
        set_mode(1'b0, 1'b0, 1'b0, 1'b0);
        ss_set(1'b0);
        m = 8'($urandom_range(255));
        full_byte(m, "post_rst");
        rd_check(A_SPSR, 8'h80, "post_rst_spif");
        rd_check(A_SPDR, m, "post_rst_rx");
        ss_set(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
